// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit. It requests one 32-bit word at a time from
// instruction memory, issues it to the decoder, then computes the next PC from
// the decoder's branch request. A HALT opcode (bits [31:27] all ones) parks the
// unit until reset.
//
// Ports
//   clk         in   rising-edge clock for all state
//   rst_n       in   synchronous active-low reset
//   imem_addr   out  instruction word address (current PC)
//   imem_req    out  fetch request, held high until imem_valid
//   imem_data   in   instruction word, valid while imem_valid=1
//   imem_valid  in   one-cycle response strobe
//   op_code     out  issued instruction, 32'h0 (NOP) when not valid
//   op_valid    out  op_code holds a live instruction
//   stall       in   downstream hold of the issued instruction
//   j           in   decoder jump request, qualified by op_valid
//   mode_set    in   0=BZ, 1=BNZ, 2=JMP, 3=JMR
//   imm_offset  in   immediate branch offset (two's complement)
//   reg_offset  in   register branch offset (two's complement)
//   offset_sel  in   0 selects imm_offset, 1 selects reg_offset
//   zero        in   ALU zero flag
//   pc          out  address of the instruction in op_code
//   halted      out  high while parked after a HALT opcode
// -----------------------------------------------------------------------------
module instr_fetch (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_data,
   input  logic        imem_valid,
   output logic [31:0] op_code,
   output logic        op_valid,
   input  logic        stall,
   input  logic        j,
   input  logic [1:0]  mode_set,
   input  logic [15:0] imm_offset,
   input  logic [15:0] reg_offset,
   input  logic        offset_sel,
   input  logic        zero,
   output logic [15:0] pc,
   output logic        halted
);

   typedef enum logic [1:0] {
      StReset,
      StFetch,
      StIssue,
      StHalt
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

   logic        halt_op;
   logic        branch_cond;
   logic        taken;
   logic [15:0] offset;
   logic [15:0] pc_step;

   assign halt_op = (imem_data[31:27] == 5'd31);

   // Branch decision; only consumed in the issue cycle, so the inputs are
   // don't-care whenever op_valid is low.
   always_comb begin
      branch_cond = 1'b1;
      case (mode_set)
         2'd0:    branch_cond = zero;
         2'd1:    branch_cond = ~zero;
         default: branch_cond = 1'b1;
      endcase
      taken   = j & branch_cond;
      offset  = offset_sel ? reg_offset : imm_offset;
      pc_step = taken ? offset : 16'd1;
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StReset;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StReset: state_d = StFetch;
         StFetch: begin
            if (imem_valid) begin
               state_d = halt_op ? StHalt : StIssue;
            end
         end
         StIssue: begin
            if (!stall) begin
               state_d = StFetch;
            end
         end
         StHalt:  state_d = StHalt;
      endcase
   end

   // Datapath next values.
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      unique case (state_q)
         StReset: begin
            pc_d    = '0;
            instr_d = '0;
         end
         StFetch: begin
            // A HALT word is never issued, so it is not captured.
            if (imem_valid && !halt_op) begin
               instr_d = imem_data;
            end
         end
         StIssue: begin
            if (!stall) begin
               pc_d    = pc_q + pc_step;  // 16-bit wrap is intended
               instr_d = '0;
            end
         end
         StHalt:  instr_d = '0;
      endcase
   end

   // Outputs are pure functions of the registered state.
   always_comb begin
      imem_req  = (state_q == StFetch);
      imem_addr = pc_q;
      op_valid  = (state_q == StIssue);
      op_code   = (state_q == StIssue) ? instr_q : '0;
      halted    = (state_q == StHalt);
      pc        = pc_q;
   end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_data;
   logic        imem_valid;
   logic [31:0] op_code;
   logic        op_valid;
   logic        stall;
   logic        j;
   logic [1:0]  mode_set;
   logic [15:0] imm_offset;
   logic [15:0] reg_offset;
   logic        offset_sel;
   logic        zero;
   logic [15:0] pc;
   logic        halted;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_issue = 0;
   int t0 = 0;

   // Reference model state: the PC the unit should be working on and the word
   // most recently handed to the decoder.
   logic [15:0] m_pc = '0;
   logic [31:0] m_instr = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   instr_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .imem_data  (imem_data),
      .imem_valid (imem_valid),
      .op_code    (op_code),
      .op_valid   (op_valid),
      .stall      (stall),
      .j          (j),
      .mode_set   (mode_set),
      .imm_offset (imm_offset),
      .reg_offset (reg_offset),
      .offset_sel (offset_sel),
      .zero       (zero),
      .pc         (pc),
      .halted     (halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic junk_branch();
      j          = 1'($urandom);
      mode_set   = 2'($urandom);
      zero       = 1'($urandom);
      imm_offset = 16'($urandom);
      reg_offset = 16'($urandom);
      offset_sel = 1'($urandom);
   endtask

   // Next PC straight from the branch rules: conditional on mode, 16-bit wrap.
   function automatic logic [15:0] model_next(input logic [15:0] cur, input logic jj,
                                              input logic [1:0] md, input logic zz,
                                              input logic [15:0] imm, input logic [15:0] rg,
                                              input logic sel);
      bit cond;
      if (md == 2'd0)      cond = zz;
      else if (md == 2'd1) cond = !zz;
      else                 cond = 1'b1;
      if (jj && cond) return cur + (sel ? rg : imm);
      return cur + 16'd1;
   endfunction

   task automatic chk_fetch(input string tag);
      chk({tag, "_req"},    32'(imem_req),  32'd1);
      chk({tag, "_addr"},   32'(imem_addr), 32'(m_pc));
      chk({tag, "_opv"},    32'(op_valid),  32'd0);
      chk({tag, "_opc"},    op_code,        32'd0);
      chk({tag, "_halted"}, 32'(halted),    32'd0);
   endtask

   // Entered at a negedge in the fetch state; returns at the negedge of the
   // issue (or halt) cycle with that cycle already checked.
   task automatic do_fetch(input logic [31:0] data, input int lat, input string tag);
      for (int i = 0; i < lat; i++) begin
         chk_fetch(tag);
         junk_branch();
         imem_valid = 1'b0;
         imem_data  = $urandom;
         step();
      end
      chk_fetch(tag);
      junk_branch();
      imem_valid = 1'b1;
      imem_data  = data;
      step();
      imem_valid = 1'b0;
      imem_data  = $urandom;
      if (data[31:27] == 5'd31) begin
         chk({tag, "_hlt_halted"}, 32'(halted),   32'd1);
         chk({tag, "_hlt_opv"},    32'(op_valid), 32'd0);
         chk({tag, "_hlt_opc"},    op_code,       32'd0);
         chk({tag, "_hlt_req"},    32'(imem_req), 32'd0);
      end else begin
         m_instr    = data;
         last_issue = cyc;
         chk({tag, "_iss_opv"}, 32'(op_valid), 32'd1);
         chk({tag, "_iss_opc"}, op_code,       m_instr);
         chk({tag, "_iss_pc"},  32'(pc),       32'(m_pc));
         chk({tag, "_iss_req"}, 32'(imem_req), 32'd0);
      end
   endtask

   // Entered at the checked issue negedge; returns at the next fetch negedge.
   task automatic do_issue(input int stalls, input logic jj, input logic [1:0] md,
                           input logic zz, input logic [15:0] imm, input logic [15:0] rg,
                           input logic sel, input string tag);
      for (int k = 0; k < stalls; k++) begin
         stall = 1'b1;
         junk_branch();
         j          = 1'b1;
         imem_valid = 1'($urandom);
         step();
         chk({tag, "_stl_opc"}, op_code,       m_instr);
         chk({tag, "_stl_opv"}, 32'(op_valid), 32'd1);
         chk({tag, "_stl_pc"},  32'(pc),       32'(m_pc));
         chk({tag, "_stl_req"}, 32'(imem_req), 32'd0);
      end
      stall      = 1'b0;
      j          = jj;
      mode_set   = md;
      zero       = zz;
      imm_offset = imm;
      reg_offset = rg;
      offset_sel = sel;
      imem_valid = 1'($urandom);
      m_pc = model_next(m_pc, jj, md, zz, imm, rg, sel);
      step();
      imem_valid = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      stall      = 1'b0;
      imem_valid = 1'b0;
      imem_data  = '0;
      junk_branch();
      step();
      step();
      chk("rst_req",    32'(imem_req),  32'd0);
      chk("rst_addr",   32'(imem_addr), 32'd0);
      chk("rst_opv",    32'(op_valid),  32'd0);
      chk("rst_opc",    op_code,        32'd0);
      chk("rst_pc",     32'(pc),        32'd0);
      chk("rst_halted", 32'(halted),    32'd0);
      // A response during the RESET cycle must be dropped.
      rst_n      = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 32'h1357_9BDF;
      step();
      imem_valid = 1'b0;
      m_pc = '0;

      // Sequential fetch with a one-cycle memory.
      do_fetch(32'h1000_0000, 1, "seq0");
      t0 = last_issue;
      do_issue(0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, "seq0");
      do_fetch(32'h1080_0000, 1, "seq1");
      chk("seq_gap1", 32'(last_issue - t0), 32'd3);
      t0 = last_issue;
      do_issue(0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, "seq1");
      do_fetch(32'h1100_0000, 1, "seq2");
      chk("seq_gap2", 32'(last_issue - t0), 32'd3);
      chk("seq2_pc", 32'(pc), 32'd2);

      // Stall at PC=5.
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'd3, 16'h0, 1'b0, "to5");
      do_fetch($urandom, 0, "pc5");
      chk("pc5", 32'(pc), 32'd5);
      do_issue(4, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, "stall");
      chk("after_stall_req",  32'(imem_req),  32'd1);
      chk("after_stall_addr", 32'(imem_addr), 32'd6);

      // Branches at PC=10.
      do_fetch(32'h2000_0001, 2, "pc6");
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'd4, 16'h0, 1'b0, "to10a");
      do_fetch(32'h2000_0002, 1, "pc10a");
      chk("pc10a", 32'(pc), 32'd10);
      do_issue(0, 1'b1, 2'd0, 1'b1, 16'hFFFC, 16'h0, 1'b0, "bz_t");
      chk("bz_taken_addr", 32'(imem_addr), 32'd6);
      do_fetch(32'h2000_0003, 1, "b1");
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'd4, 16'h0, 1'b0, "to10b");
      do_fetch(32'h2000_0004, 1, "pc10b");
      do_issue(1, 1'b1, 2'd0, 1'b0, 16'hFFFC, 16'h0, 1'b0, "bz_nt");
      chk("bz_not_taken_addr", 32'(imem_addr), 32'd11);
      do_fetch(32'h2000_0005, 1, "b2");
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'hFFFF, 16'h0, 1'b0, "to10c");
      do_fetch(32'h2000_0006, 1, "pc10c");
      do_issue(0, 1'b1, 2'd1, 1'b0, 16'hFFFC, 16'h0, 1'b0, "bnz_t");
      chk("bnz_taken_addr", 32'(imem_addr), 32'd6);
      do_fetch(32'h2000_0007, 1, "b3");
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'd4, 16'h0, 1'b0, "to10d");
      do_fetch(32'h2000_0008, 1, "pc10d");
      do_issue(0, 1'b1, 2'd3, 1'b0, 16'h1234, 16'h0020, 1'b1, "jmr");
      chk("jmr_addr", 32'(imem_addr), 32'h2A);
      do_fetch(32'h2000_0009, 0, "b4");
      do_issue(0, 1'b0, 2'd2, 1'b1, 16'h0100, 16'h0200, 1'b0, "nojmp");
      chk("no_j_addr", 32'(imem_addr), 32'h2B);

      // Wrap-around.
      do_fetch(32'h3000_0000, 1, "w0");
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'hFFD4, 16'h0, 1'b0, "toffff");
      do_fetch(32'h3000_0001, 1, "wffff");
      chk("pc_ffff", 32'(pc), 32'hFFFF);
      do_issue(0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, "wrap1");
      chk("wrap_inc_addr", 32'(imem_addr), 32'h0);
      do_fetch(32'h3000_0002, 1, "w1");
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'hFFFE, 16'h0, 1'b0, "tofffe");
      do_fetch(32'h3000_0003, 1, "wfffe");
      chk("pc_fffe", 32'(pc), 32'hFFFE);
      do_issue(0, 1'b1, 2'd2, 1'b0, 16'd3, 16'hFFFF, 1'b0, "wrapjmp");
      chk("wrap_jmp_addr", 32'(imem_addr), 32'h1);

      // Randomized fetch/issue traffic.
      for (int n = 0; n < 40; n++) begin
         logic [31:0] d;
         d = $urandom;
         if (d[31:27] == 5'd31) d[31] = 1'b0;
         do_fetch(d, int'($urandom_range(0, 3)), "rnd");
         do_issue(int'($urandom_range(0, 2)), 1'($urandom), 2'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom), 1'($urandom), "rnd");
      end

      // Reset in the middle of an outstanding fetch.
      chk("mid_req", 32'(imem_req), 32'd1);
      rst_n = 1'b0;
      step();
      chk("mid_rst_req", 32'(imem_req), 32'd0);
      chk("mid_rst_pc",  32'(pc),       32'd0);
      chk("mid_rst_opv", 32'(op_valid), 32'd0);
      rst_n      = 1'b1;
      imem_valid = 1'b1;
      imem_data  = 32'hDEAD_BEEF;
      step();
      imem_valid = 1'b0;
      m_pc = '0;
      do_fetch(32'h1234_5678, 1, "post_rst");
      chk("post_rst_pc", 32'(pc), 32'd0);
      do_issue(0, 1'b0, 2'd0, 1'b0, 16'h0, 16'h0, 1'b0, "post_rst");

      // HALT, then restart via reset.
      do_fetch(32'hF800_0000, 1, "halt");
      for (int k = 0; k < 20; k++) begin
         stall      = 1'($urandom);
         imem_valid = 1'($urandom);
         imem_data  = $urandom;
         junk_branch();
         step();
         chk("halt_hold_halted", 32'(halted),   32'd1);
         chk("halt_hold_req",    32'(imem_req), 32'd0);
         chk("halt_hold_opv",    32'(op_valid), 32'd0);
         chk("halt_hold_opc",    op_code,       32'd0);
      end
      stall      = 1'b0;
      imem_valid = 1'b0;
      rst_n      = 1'b0;
      step();
      chk("halt_rst_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;
      step();
      m_pc = '0;
      do_fetch(32'h1000_0000, 0, "restart");
      chk("restart_pc", 32'(pc), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-low reset, with ports as listed below (clock and reset first).
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RST_N  in  1  synchronous, active-low reset; sampled on CLK rising edge.
REQ-004 IMEM_ADDR  out  16  instruction word address.
REQ-005 IMEM_REQ  out  1  fetch request; held high until the response arrives.
REQ-006 IMEM_DATA  in  32  instruction word; valid only while IMEM_VALID=1.
REQ-007 IMEM_VALID  in  1  one-cycle response strobe for the outstanding request.
REQ-008 OP_CODE  out  32  instruction issued to the decoder; 32'h0 (NOP) when not valid.
REQ-009 OP_VALID  out  1  OP_CODE holds a live instruction.
REQ-010 STALL  in  1  downstream hold; the issued instruction is kept unchanged.
REQ-011 J  in  1  decoder jump request; qualified by OP_VALID.
REQ-012 MODE_SET  in  2  branch mode: 0=BZ, 1=BNZ, 2=JMP, 3=JMR.
REQ-013 IMM_OFFSET  in  16  immediate branch offset.
REQ-014 REG_OFFSET  in  16  register-file offset, used when OFFSET_SEL=1.
REQ-015 OFFSET_SEL  in  1  0 selects IMM_OFFSET; 1 selects REG_OFFSET.
REQ-016 ZERO  in  1  ALU zero flag.
REQ-017 PC  out  16  address of the instruction currently in OP_CODE.
REQ-018 HALTED  out  1  high once a HALT opcode has been fetched.

Function
REQ-019 States SHALL be RESET, FETCH, ISSUE and HALT, with one state active per cycle.
REQ-020 RESET SHALL last exactly one cycle after RST_N is released, then go to FETCH with PC=0.
REQ-021 FETCH SHALL drive IMEM_REQ=1 and IMEM_ADDR=PC, and stay in FETCH until IMEM_VALID=1.
REQ-022 On IMEM_VALID in FETCH, the next cycle SHALL have OP_CODE=IMEM_DATA, OP_VALID=1 and state ISSUE.
REQ-023 IMEM_REQ SHALL drop in the cycle after IMEM_VALID, giving a fetch-to-issue latency of 1 cycle after the response.
REQ-024 IMEM_VALID outside FETCH SHALL be ignored.
REQ-025 If IMEM_DATA[31:27]=5'd31, the block SHALL enter HALT instead of ISSUE.
REQ-026 In HALT: HALTED=1, OP_VALID=0, OP_CODE=0, IMEM_REQ=0; the block SHALL remain in HALT until reset.
REQ-027 ISSUE with STALL=1 SHALL hold OP_CODE, OP_VALID, PC and state unchanged, and J SHALL be ignored.
REQ-028 ISSUE with STALL=0 SHALL evaluate the branch in that cycle, then go to FETCH.
REQ-029 Branch taken = J & (MODE_SET==0 ? ZERO : MODE_SET==1 ? ~ZERO : 1).
REQ-030 Next PC SHALL be PC + (OFFSET_SEL ? REG_OFFSET : IMM_OFFSET) if taken, else PC + 1.
REQ-031 PC arithmetic SHALL be 16-bit modulo 2^16; offsets are two's complement, so 16'hFFFF + 1 = 0.
REQ-032 On leaving ISSUE, the block SHALL drive OP_VALID=0 and OP_CODE=0 for the whole FETCH period, so the decoder sees only NOPs.
REQ-033 J, MODE_SET, ZERO and both offsets SHALL be ignored whenever OP_VALID=0.

Reset
REQ-034 When RST_N=0 at a rising edge, the next state SHALL be: state RESET, PC=0, IMEM_ADDR=0, IMEM_REQ=0, OP_CODE=0, OP_VALID=0, HALTED=0.
REQ-035 Reset SHALL take precedence over every other event, including a pending IMEM_VALID or STALL and the HALT state.
REQ-036 A fetch outstanding at reset SHALL be abandoned, and an IMEM_VALID arriving during RESET SHALL be discarded.

Verification
REQ-037 Sequential fetch: 1-cycle memory returning 0x10000000, 0x10800000, 0x11000000 -> OP_VALID pulses with PC=0, 1, 2; exactly 3 cycles between issues.
REQ-038 Stall: STALL=1 for 4 cycles during ISSUE at PC=5 -> OP_CODE, PC and OP_VALID held, no IMEM_REQ; fetch of PC=6 starts the cycle after STALL falls.
REQ-039 Branches at PC=10 with IMM_OFFSET=16'hFFFC -> BZ/ZERO=1 gives PC=6; BZ/ZERO=0 gives PC=11; BNZ/ZERO=0 gives PC=6; JMR with REG_OFFSET=0x0020 gives PC=0x002A.
REQ-040 Wrap-around: PC=0xFFFF, no jump -> next PC=0x0000; JMP from 0xFFFE with IMM_OFFSET=3 -> PC=0x0001.
REQ-041 HALT: IMEM_DATA=0xF8000000 -> HALTED=1 and no further IMEM_REQ for 20 cycles; RST_N pulse -> fetch restarts at PC=0.
REQ-042 Reset mid-fetch: RST_N=0 while IMEM_REQ=1, IMEM_VALID arriving one cycle later -> data discarded; first post-reset issue has PC=0 with the new response.
